exec_dispatch: RTL and testbench

- Parametrised successor to the execute-stage arbiter. Dispatches each decoded instruction to one of NUM_UNITS functional units (ALU, misc, pcrel, mem, csr, ...).
- Units may be multi-cycle and may complete out of order relative to one another. A unit-tag order FIFO guarantees results leave in program order.
- The output channel supports backpressure; the previous arbiter's output could not be stalled.
- Sits between decode and writeback/commit.

---
 rtl/exec_dispatch.sv | 138 +++++++++++++
 tb/tb_exec_dispatch.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_dispatch.sv
// exec_dispatch: execute-stage dispatcher with in-order retirement.
//
// Each decoded instruction goes to one of NUM_UNITS functional units, picked
// by in_unit. The unit index is also pushed into a small order FIFO. Results
// leave through a single backpressured output channel in program order. Units
// may finish in any order. A unit whose result is not at the FIFO head keeps
// holding it until its tag reaches the head.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           squash everything in flight this cycle
//   in_valid/ready  decoded-instruction handshake
//   in_data         decoded instruction, broadcast unchanged on unit_data
//   in_unit         target unit index; out-of-range indices are dropped
//   unit_valid      one-hot issue valid, one bit per unit
//   unit_ready      per-unit issue ready
//   unit_data       broadcast issue payload
//   unit_res_valid  per-unit result valid
//   unit_res_ready  per-unit result accept (all ones during flush)
//   unit_res_data   unit i result at bits [i*RES_W +: RES_W]
//   out_valid/ready in-order result handshake
//   out_data        in-order result
//   inflight        order FIFO occupancy
//   err_unit        one-cycle pulse after an out-of-range in_unit is consumed
module exec_dispatch #(
  parameter int NUM_UNITS = 5,
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 128,
  parameter int RES_W     = 64,
  parameter int UNIT_W    = $clog2(NUM_UNITS),
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [UNIT_W-1:0]          in_unit,
  output logic [NUM_UNITS-1:0]       unit_valid,
  input  logic [NUM_UNITS-1:0]       unit_ready,
  output logic [DATA_W-1:0]          unit_data,
  input  logic [NUM_UNITS-1:0]       unit_res_valid,
  output logic [NUM_UNITS-1:0]       unit_res_ready,
  input  logic [NUM_UNITS*RES_W-1:0] unit_res_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RES_W-1:0]           out_data,
  output logic [CNT_W-1:0]           inflight,
  output logic                       err_unit
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Widths are pinned so every compare below is between equal-width operands.
  localparam logic [UNIT_W:0]   NUM_C   = (UNIT_W + 1)'(NUM_UNITS);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_C  = PTR_W'(DEPTH - 1);

  logic [UNIT_W-1:0] tag_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [UNIT_W-1:0] head_tag;
  logic              sel_ok;
  logic              not_full;
  logic              not_empty;
  logic              push;
  logic              pop;
  logic              drop;

  // Wrap explicitly at DEPTH-1 so non-power-of-2 depths stay correct.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  assign sel_ok    = {1'b0, in_unit} < NUM_C;
  // Fullness uses the registered occupancy only. A pop in the same cycle does
  // not free a slot for issue.
  assign not_full  = inflight < DEPTH_C;
  assign not_empty = inflight != '0;
  assign head_tag  = tag_mem[head];
  assign unit_data = in_data;

  // Issue side
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned and infers a latch.
    unit_valid = '0;
    if (in_valid && !flush && not_full && sel_ok)
      unit_valid[in_unit] = 1'b1;
    // An out-of-range unit is accepted without waiting on any unit ready.
    in_ready = !flush && not_full && (!sel_ok || unit_ready[in_unit]);
  end

  assign push = in_valid && in_ready && sel_ok;
  assign drop = in_valid && in_ready && !sel_ok;

  // Retire side. Only the head unit is ever offered ready, so results that
  // finish out of order stay parked in their own units.
  always_comb begin
    out_valid = !flush && not_empty && unit_res_valid[head_tag];
    out_data  = unit_res_data[int'(head_tag)*RES_W +: RES_W];
    unit_res_ready = '0;
    if (flush)
      unit_res_ready = '1;
    else if (not_empty && out_ready)
      unit_res_ready[head_tag] = 1'b1;
  end

  assign pop = out_valid && out_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples its pre-edge inputs, whatever the statement order.
    if (rst || flush) begin
      head     <= '0;
      tail     <= '0;
      inflight <= '0;
      err_unit <= 1'b0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      case ({push, pop})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      err_unit <= drop;
    end
  end

  // NOTE: the tag storage has no reset. Entries are only read between head
  // and tail, and those pointers are reset, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (push) tag_mem[tail] <= in_unit;
  end

endmodule

// File: tb/tb_exec_dispatch.sv
// tb_exec_dispatch: self-checking bench for exec_dispatch.
//
// The functional units are emulated in the bench. The reference model is a
// single program-order list of outstanding jobs. Each job holds its unit, its
// result value and the first cycle its result is available. A unit presents
// the oldest job that targets it, and the dispatcher must retire the front of
// the list. One compare step runs every cycle and checks every DUT output
// against that list. Directed sequences pin the model with literal values, and
// a random phase follows. The DUT is built with DEPTH=3 so that pointer wrap
// runs on a non-power-of-2 depth.
module tb_exec_dispatch;

  localparam int NU    = 5;
  localparam int DEPTH = 3;
  localparam int DW    = 128;
  localparam int RW    = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [2:0]      in_unit;
  logic [NU-1:0]   unit_valid;
  logic [NU-1:0]   unit_ready;
  logic [DW-1:0]   unit_data;
  logic [NU-1:0]   unit_res_valid;
  logic [NU-1:0]   unit_res_ready;
  logic [NU*RW-1:0] unit_res_data;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   out_data;
  logic [1:0]      inflight;
  logic            err_unit;

  exec_dispatch #(.NUM_UNITS(NU), .DEPTH(DEPTH), .DATA_W(DW), .RES_W(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_unit(in_unit),
    .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_data(unit_data),
    .unit_res_valid(unit_res_valid), .unit_res_ready(unit_res_ready),
    .unit_res_data(unit_res_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .inflight(inflight), .err_unit(err_unit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           unit;
    logic [RW-1:0] val;
    int           rdy;
  } job_t;

  job_t          prog_q[$];
  logic [RW-1:0] out_log[$];
  bit            exp_err;
  bit            model_ok;
  int            cyc;
  int            n_pass;
  int            n_checks;

  // Stimulus for the next cycle
  logic          d_rst, d_flush, d_in_valid, d_out_ready;
  logic [2:0]    d_in_unit;
  logic [DW-1:0] d_in_data;
  logic [NU-1:0] d_unit_ready;
  // Forced result value and latency for the next issued job (directed tests)
  bit            f_use;
  int            f_lat;
  logic [RW-1:0] f_val;
  bit            last_fire;

  // DUT outputs sampled in the most recent cycle
  logic          s_in_ready, s_out_valid, s_err;
  logic [NU-1:0] s_unit_valid, s_urr;
  logic [RW-1:0] s_out_data;
  logic [1:0]    s_inflight;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [RW-1:0] log_at(input int k);
    return (k < out_log.size()) ? out_log[k] : '1;
  endfunction

  // One clock cycle: drive at negedge, compare 1 time unit later, advance the
  // model at the posedge.
  task automatic cycle();
    job_t          j;
    logic [NU-1:0] res_v, e_uv, e_urr;
    logic          e_ir, e_ov;
    int            occ;
    bit            fire_in, fire_out, seen;

    @(negedge clk);
    rst        = d_rst;
    flush      = d_flush;
    in_valid   = d_in_valid;
    in_unit    = d_in_unit;
    in_data    = d_in_data;
    unit_ready = d_unit_ready;
    out_ready  = d_out_ready;

    // Each unit presents its oldest outstanding job once that job is ready.
    res_v = '0;
    for (int u = 0; u < NU; u++) begin
      unit_res_data[u*RW +: RW] = {$urandom, $urandom};
      seen = 1'b0;
      for (int k = 0; k < prog_q.size(); k++) begin
        if (!seen && prog_q[k].unit == u) begin
          seen = 1'b1;
          if (prog_q[k].rdy <= cyc) begin
            res_v[u] = 1'b1;
            unit_res_data[u*RW +: RW] = prog_q[k].val;
          end
        end
      end
    end
    unit_res_valid = res_v;

    #1;
    occ   = prog_q.size();
    e_ir  = !d_flush && occ < DEPTH && (d_in_unit >= NU || d_unit_ready[d_in_unit]);
    e_uv  = (d_in_valid && !d_flush && occ < DEPTH && d_in_unit < NU) ? NU'(1 << d_in_unit) : '0;
    e_ov  = !d_flush && occ > 0 && prog_q[0].rdy <= cyc;
    e_urr = d_flush ? '1 : ((occ > 0 && d_out_ready) ? NU'(1 << prog_q[0].unit) : '0);

    s_in_ready   = in_ready;
    s_unit_valid = unit_valid;
    s_urr        = unit_res_ready;
    s_out_valid  = out_valid;
    s_out_data   = out_data;
    s_inflight   = inflight;
    s_err        = err_unit;

    if (model_ok) begin
      check("in_ready", in_ready, e_ir);
      check("unit_valid", unit_valid, e_uv);
      check("unit_res_ready", unit_res_ready, e_urr);
      check("out_valid", out_valid, e_ov);
      if (e_ov) check("out_data", out_data, prog_q[0].val);
      check("inflight", inflight, occ);
      check("err_unit", err_unit, exp_err);
      check("unit_data", unit_data, d_in_data);
    end
    if (out_valid && out_ready) out_log.push_back(out_data);

    fire_in   = d_in_valid && e_ir;
    fire_out  = e_ov && d_out_ready;
    last_fire = fire_in;

    @(posedge clk);
    if (d_rst) begin
      prog_q.delete();
      exp_err  = 1'b0;
      model_ok = 1'b1;
    end else if (d_flush) begin
      prog_q.delete();
      exp_err = 1'b0;
    end else begin
      if (fire_out) void'(prog_q.pop_front());
      if (fire_in && d_in_unit < NU) begin
        j.unit = int'(d_in_unit);
        j.val  = f_use ? f_val : {$urandom, $urandom};
        j.rdy  = cyc + (f_use ? f_lat : int'($urandom_range(1, 6)));
        prog_q.push_back(j);
      end
      exp_err = fire_in && d_in_unit >= NU;
    end
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_checks = 0; cyc = 0; model_ok = 0; exp_err = 0; last_fire = 0;
    d_rst = 1; d_flush = 0; d_in_valid = 0; d_in_unit = 0; d_in_data = '0;
    d_unit_ready = '1; d_out_ready = 1; f_use = 1; f_lat = 1; f_val = '0;
    cycle();
    cycle();
    d_rst = 0;

    // Reset state
    cycle();
    check("rst_inflight", s_inflight, 0);
    check("rst_out_valid", s_out_valid, 0);
    check("rst_unit_res_ready", s_urr, 0);
    check("rst_err", s_err, 0);

    // Single ALU op: result 0xAB one cycle after issue
    d_in_valid = 1; d_in_unit = 1; d_in_data = 128'h1234; f_val = 64'hAB; f_lat = 1;
    cycle();
    check("alu_in_ready", s_in_ready, 1);
    check("alu_unit_valid", s_unit_valid, 5'b00010);
    check("alu_inflight0", s_inflight, 0);
    d_in_valid = 0;
    cycle();
    check("alu_out_valid", s_out_valid, 1);
    check("alu_out_data", s_out_data, 64'hAB);
    check("alu_inflight1", s_inflight, 1);
    cycle();
    check("alu_inflight_back", s_inflight, 0);
    check("alu_out_idle", s_out_valid, 0);

    // Out-of-order completion: slow mem op, then fast ALU op
    out_log.delete();
    d_in_valid = 1; d_in_unit = 3; f_val = 64'h3333; f_lat = 4;
    cycle();
    d_in_unit = 1; f_val = 64'h1111; f_lat = 1;
    cycle();
    d_in_valid = 0;
    cycle();
    check("ooo_urr_head_only", s_urr, 5'b01000);
    check("ooo_head_waits", s_out_valid, 0);
    repeat (6) cycle();
    check("ooo_count", out_log.size(), 2);
    check("ooo_first_mem", log_at(0), 64'h3333);
    check("ooo_second_alu", log_at(1), 64'h1111);

    // Full FIFO and output backpressure
    d_out_ready = 0; d_in_valid = 1; f_lat = 1;
    for (int k = 0; k < DEPTH; k++) begin
      d_in_unit = 3'(k); f_val = 64'hF0 + 64'(k);
      cycle();
      check("fill_accept", s_in_ready, 1);
    end
    d_in_unit = 3'(DEPTH); f_val = 64'hF3;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("full_block", s_in_ready, 0);
      check("full_inflight", s_inflight, DEPTH);
      check("bp_out_valid", s_out_valid, 1);
      check("bp_out_data", s_out_data, 64'hF0);
    end
    d_out_ready = 1;
    cycle();
    check("pop_no_bypass", s_in_ready, 0);
    check("pop_fires", s_out_valid, 1);
    cycle();
    check("next_accept", s_in_ready, 1);
    check("next_inflight", s_inflight, DEPTH - 1);
    d_in_valid = 0;
    repeat (6) cycle();
    check("full_drained", s_inflight, 0);

    // Flush with three in flight and one result presented
    d_out_ready = 0; d_in_valid = 1;
    d_in_unit = 0; f_val = 64'hA0; f_lat = 1;  cycle();
    d_in_unit = 2; f_val = 64'hA2; f_lat = 50; cycle();
    d_in_unit = 4; f_val = 64'hA4; f_lat = 50; cycle();
    d_in_unit = 1; d_flush = 1;
    cycle();
    check("flush_urr_all", s_urr, 5'b11111);
    check("flush_no_out", s_out_valid, 0);
    check("flush_no_issue", s_unit_valid, 0);
    check("flush_in_ready", s_in_ready, 0);
    d_flush = 0; d_in_valid = 0;
    cycle();
    check("flush_cleared", s_inflight, 0);
    out_log.delete();
    d_out_ready = 1; d_in_valid = 1; d_in_unit = 0; f_val = 64'h77; f_lat = 2;
    cycle();
    d_in_valid = 0;
    repeat (4) cycle();
    check("post_flush_count", out_log.size(), 1);
    check("post_flush_data", log_at(0), 64'h77);

    // Out-of-range unit index
    d_in_valid = 1; d_in_unit = 7;
    cycle();
    check("bad_in_ready", s_in_ready, 1);
    check("bad_no_issue", s_unit_valid, 0);
    d_in_valid = 0;
    cycle();
    check("bad_err_pulse", s_err, 1);
    check("bad_inflight", s_inflight, 0);
    cycle();
    check("bad_err_once", s_err, 0);

    // Wrap: 10 back-to-back ops with simultaneous push and pop
    out_log.delete();
    d_out_ready = 1; d_unit_ready = '1; d_in_valid = 1; f_lat = 1;
    for (int k = 0; k < 10; k++) begin
      d_in_unit = 3'(k % NU); f_val = 64'h100 + 64'(k);
      cycle();
    end
    d_in_valid = 0;
    repeat (4) cycle();
    check("wrap_count", out_log.size(), 10);
    for (int k = 0; k < 10; k++) check("wrap_data", log_at(k), 64'h100 + 64'(k));

    // Random traffic: decode holds an instruction until it is accepted
    f_use = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!d_in_valid || last_fire || d_rst) begin
        d_in_valid = $urandom_range(0, 3) != 0;
        d_in_unit  = ($urandom_range(0, 9) == 0) ? 3'(5 + $urandom_range(0, 2))
                                                 : 3'($urandom_range(0, NU - 1));
        d_in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      d_unit_ready = NU'($urandom);
      d_out_ready  = $urandom_range(0, 3) != 0;
      d_flush      = $urandom_range(0, 39) == 0;
      d_rst        = $urandom_range(0, 299) == 0;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
